vga_text_term_ctrl: RTL and testbench

//  Terminal-style sequencer for the write port of the VGA text buffer (enter/data/dataX/dataY).

---
 rtl/vga_text_term_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_text_term_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_term_ctrl
// Description : Terminal-style write sequencer for the VGA text buffer. It
//               turns a byte stream into cell writes, row clears and
//               full-screen clears, and tracks the cursor position.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_term_ctrl #(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 30,
    parameter logic [7:0]  FILL_CHAR = 8'd32
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       enter,
    output logic [7:0] data,
    output logic [9:0] dataX,
    output logic [9:0] dataY,
    output logic [9:0] cur_x,
    output logic [9:0] cur_y,
    output logic       busy
);

    localparam logic [9:0] C_LAST_COL = 10'(COLS - 1);
    localparam logic [9:0] C_LAST_ROW = 10'(ROWS - 1);
    localparam logic [7:0] C_BS       = 8'h08;
    localparam logic [7:0] C_LF       = 8'h0A;
    localparam logic [7:0] C_FF       = 8'h0C;
    localparam logic [7:0] C_CR       = 8'h0D;
    localparam logic [7:0] C_DEL      = 8'h7F;

    typedef enum logic [1:0] {
        CLR_SCR = 2'd0,
        IDLE    = 2'd1,
        PUT     = 2'd2,
        CLR_ROW = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] cur_x_q, cur_x_d;
    logic [9:0] cur_y_q, cur_y_d;
    logic [9:0] clr_x_q, clr_x_d;
    logic [9:0] clr_y_q, clr_y_d;
    logic       adv_q, adv_d;
    logic       enter_q, enter_d;
    logic [7:0] data_q, data_d;
    logic [9:0] dx_q, dx_d;
    logic [9:0] dy_q, dy_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;

    logic       w_accept;
    logic       w_printable;
    logic [9:0] w_next_row;
    logic       w_start_row;

    assign w_accept    = char_valid & ready_q;
    assign w_printable = (char_data >= 8'h20) && (char_data != C_DEL);
    assign w_next_row  = (cur_y_q == C_LAST_ROW) ? 10'd0 : cur_y_q + 10'd1;

    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        clr_x_d     = clr_x_q;
        clr_y_d     = clr_y_q;
        adv_d       = adv_q;
        enter_d     = 1'b0;
        data_d      = data_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        ready_d     = 1'b0;
        busy_d      = 1'b0;
        w_start_row = 1'b0;

        case (state_q)
            CLR_SCR: begin
                enter_d = 1'b1;
                data_d  = FILL_CHAR;
                dx_d    = clr_x_q;
                dy_d    = clr_y_q;
                busy_d  = 1'b1;
                if (clr_x_q == C_LAST_COL) begin
                    clr_x_d = 10'd0;
                    if (clr_y_q == C_LAST_ROW) begin
                        clr_y_d = 10'd0;
                        state_d = IDLE;
                    end else begin
                        clr_y_d = clr_y_q + 10'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 10'd1;
                end
            end

            IDLE: begin
                ready_d = 1'b1;
                if (w_accept) begin
                    if (w_printable) begin
                        enter_d = 1'b1;
                        data_d  = char_data;
                        dx_d    = cur_x_q;
                        dy_d    = cur_y_q;
                        adv_d   = 1'b1;
                        ready_d = 1'b0;
                        state_d = PUT;
                    end else begin
                        case (char_data)
                            C_CR: cur_x_d = 10'd0;
                            C_LF: begin
                                cur_x_d     = 10'd0;
                                cur_y_d     = w_next_row;
                                w_start_row = 1'b1;
                            end
                            C_BS: begin
                                if (cur_x_q != 10'd0) begin
                                    cur_x_d = cur_x_q - 10'd1;
                                    enter_d = 1'b1;
                                    data_d  = FILL_CHAR;
                                    dx_d    = cur_x_q - 10'd1;
                                    dy_d    = cur_y_q;
                                    adv_d   = 1'b0;
                                    ready_d = 1'b0;
                                    state_d = PUT;
                                end
                            end
                            C_FF: begin
                                cur_x_d = 10'd0;
                                cur_y_d = 10'd0;
                                clr_x_d = 10'd0;
                                clr_y_d = 10'd0;
                                busy_d  = 1'b1;
                                ready_d = 1'b0;
                                state_d = CLR_SCR;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            PUT: begin
                if (adv_q && (cur_x_q == C_LAST_COL)) begin
                    cur_x_d     = 10'd0;
                    cur_y_d     = w_next_row;
                    w_start_row = 1'b1;
                end else begin
                    if (adv_q) begin
                        cur_x_d = cur_x_q + 10'd1;
                    end
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end

            CLR_ROW: begin
                enter_d = 1'b1;
                data_d  = FILL_CHAR;
                dx_d    = clr_x_q;
                dy_d    = cur_y_q;
                busy_d  = 1'b1;
                if (clr_x_q == C_LAST_COL) begin
                    clr_x_d = 10'd0;
                    state_d = IDLE;
                end else begin
                    clr_x_d = clr_x_q + 10'd1;
                end
            end

            default: state_d = CLR_SCR;
        endcase

        // The first cell of a new row is written on the same edge that moves
        // the cursor, so the clear follows the trigger without a gap cycle.
        if (w_start_row) begin
            enter_d = 1'b1;
            data_d  = FILL_CHAR;
            dx_d    = 10'd0;
            dy_d    = w_next_row;
            clr_x_d = 10'd1;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            state_d = CLR_ROW;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= CLR_SCR;
            cur_x_q <= 10'd0;
            cur_y_q <= 10'd0;
            clr_x_q <= 10'd0;
            clr_y_q <= 10'd0;
            adv_q   <= 1'b0;
            enter_q <= 1'b0;
            data_q  <= 8'd0;
            dx_q    <= 10'd0;
            dy_q    <= 10'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
            adv_q   <= adv_d;
            enter_q <= enter_d;
            data_q  <= data_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign char_ready = ready_q;
    assign enter      = enter_q;
    assign data       = data_q;
    assign dataX      = dx_q;
    assign dataY      = dy_q;
    assign cur_x      = cur_x_q;
    assign cur_y      = cur_y_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_text_term_ctrl
// Description : Directed, table-driven bench for vga_text_term_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_text_term_ctrl;

    localparam int C_COLS  = 80;
    localparam int C_ROWS  = 30;
    localparam int C_BOUND = 3000;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'd0;
    logic       char_ready;
    logic       enter;
    logic [7:0] data;
    logic [9:0] dataX;
    logic [9:0] dataY;
    logic [9:0] cur_x;
    logic [9:0] cur_y;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    vga_text_term_ctrl #(.COLS(80), .ROWS(30), .FILL_CHAR(8'd32)) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .enter      (enter),
        .data       (data),
        .dataX      (dataX),
        .dataY      (dataY),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b;
        int         n;
        logic [7:0] d0;
        int         x0;
        int         y0;
        int         cx;
        int         cy;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one byte and return #1 after the edge that accepted it.
    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge CLK);
        char_valid = 1'b1;
        char_data  = b;
        while (!char_ready && w < C_BOUND) begin
            @(negedge CLK);
            w++;
        end
        if (w >= C_BOUND) check("accept_wait", 32'(w), 32'(C_BOUND - 1));
        @(posedge CLK);
        #1;
        char_valid = 1'b0;
        char_data  = 8'd0;
    endtask

    // Collect writes until char_ready returns; writes must walk row-major
    // from (x0,y0), first carrying d0 and the rest the fill byte.
    task automatic observe(input string name, input int n, input logic [7:0] d0,
                           input int x0, input int y0, input int cx, input int cy);
        int idx, cyc, first, last, bad, lin;
        bit done;
        logic [7:0] ed;
        idx = 0; cyc = 0; first = -1; last = -1; bad = 0; done = 1'b0;
        while (!done && cyc < C_BOUND) begin
            if (enter) begin
                lin = y0 * C_COLS + x0 + idx;
                ed  = (idx == 0) ? d0 : 8'h20;
                if (dataX !== 10'(lin % C_COLS) || dataY !== 10'((lin / C_COLS) % C_ROWS) ||
                    data !== ed || (n > 1 && idx > 0 && busy !== 1'b1)) begin
                    if (bad == 0)
                        $display("  %s write %0d: got (%0d,%0d)=%0h busy=%b wanted (%0d,%0d)=%0h",
                                 name, idx, dataX, dataY, data, busy,
                                 lin % C_COLS, (lin / C_COLS) % C_ROWS, ed);
                    bad++;
                end
                if (first < 0) first = cyc;
                idx++;
                last = cyc;
            end
            if (char_ready) begin
                done = 1'b1;
            end else begin
                @(posedge CLK);
                #1;
                cyc++;
            end
        end
        check({name, " ready_returned"}, 32'(done), 32'd1);
        check({name, " write_count"}, 32'(idx), 32'(n));
        if (n > 0) begin
            check({name, " write_pattern_errors"}, 32'(bad), 32'd0);
            check({name, " ready_after_last_write"}, 32'(cyc - last), 32'd1);
        end
        if (n == 1) check({name, " write_latency"}, 32'(first), 32'd0);
        check({name, " cur_x"}, 32'(cur_x), 32'(cx));
        check({name, " cur_y"}, 32'(cur_y), 32'(cy));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h48, 1,    8'h48, 0, 0, 1, 0};
        vecs[1]  = '{8'h69, 1,    8'h69, 1, 0, 2, 0};
        vecs[2]  = '{8'h0D, 0,    8'h00, 0, 0, 0, 0};
        vecs[3]  = '{8'h07, 0,    8'h00, 0, 0, 0, 0};
        vecs[4]  = '{8'h7F, 0,    8'h00, 0, 0, 0, 0};
        vecs[5]  = '{8'h08, 0,    8'h00, 0, 0, 0, 0};
        vecs[6]  = '{8'h41, 1,    8'h41, 0, 0, 1, 0};
        vecs[7]  = '{8'hC3, 1,    8'hC3, 1, 0, 2, 0};
        vecs[8]  = '{8'h08, 1,    8'h20, 1, 0, 1, 0};
        vecs[9]  = '{8'h0A, 80,   8'h20, 0, 1, 0, 1};
        vecs[10] = '{8'h7E, 1,    8'h7E, 0, 1, 1, 1};
        vecs[11] = '{8'h0C, 2400, 8'h20, 0, 0, 0, 0};

        repeat (3) @(posedge CLK);
        #1;
        check("reset enter", 32'(enter), 32'd0);
        check("reset char_ready", 32'(char_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset data", 32'(data), 32'd0);
        check("reset cursor", 32'({cur_x, cur_y}), 32'd0);

        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        observe("power_on_clear", 2400, 8'h20, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].b);
            observe($sformatf("vec%0d", i), vecs[i].n, vecs[i].d0,
                    vecs[i].x0, vecs[i].y0, vecs[i].cx, vecs[i].cy);
        end

        // Walk to (79,5) and wrap onto row 6.
        for (int r = 1; r <= 5; r++) begin
            send(8'h0A);
            observe($sformatf("lf_row%0d", r), 80, 8'h20, 0, r, 0, r);
        end
        for (int i = 0; i < 79; i++) begin
            send(8'h78);
            observe($sformatf("fill_x%0d", i), 1, 8'h78, i, 5, i + 1, 5);
        end
        send(8'h41);
        observe("wrap_79_5", 81, 8'h41, 79, 5, 0, 6);

        // Walk to (10,29), then LF wraps to row 0.
        for (int r = 7; r <= 29; r++) begin
            send(8'h0A);
            observe($sformatf("lf_row%0d", r), 80, 8'h20, 0, r, 0, r);
        end
        for (int i = 0; i < 10; i++) begin
            send(8'h79);
            observe($sformatf("row29_x%0d", i), 1, 8'h79, i, 29, i + 1, 29);
        end
        send(8'h0A);
        observe("lf_wrap_row0", 80, 8'h20, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            send(8'h7A);
            observe($sformatf("row0_x%0d", i), 1, 8'h7A, i, 0, i + 1, 0);
        end
        send(8'h0D);
        observe("cr_at_5_0", 0, 8'h00, 0, 0, 0, 0);

        // Backspace at (3,2) and at column 0.
        send(8'h0A);
        observe("lf_to_row1", 80, 8'h20, 0, 1, 0, 1);
        send(8'h0A);
        observe("lf_to_row2", 80, 8'h20, 0, 2, 0, 2);
        for (int i = 0; i < 3; i++) begin
            send(8'h62);
            observe($sformatf("row2_x%0d", i), 1, 8'h62, i, 2, i + 1, 2);
        end
        send(8'h08);
        observe("bs_at_3_2", 1, 8'h20, 2, 2, 2, 2);
        send(8'h08);
        observe("bs_at_2_2", 1, 8'h20, 1, 2, 1, 2);
        send(8'h08);
        observe("bs_at_1_2", 1, 8'h20, 0, 2, 0, 2);
        send(8'h08);
        observe("bs_at_0_2", 0, 8'h00, 0, 0, 0, 2);

        // Asynchronous reset in the middle of a row clear.
        send(8'h0A);
        repeat (10) @(posedge CLK);
        #3;
        check("mid_row busy_before_reset", 32'(busy), 32'd1);
        RST_N = 1'b0;
        #1;
        check("async_reset enter", 32'(enter), 32'd0);
        check("async_reset cur_x", 32'(cur_x), 32'd0);
        check("async_reset cur_y", 32'(cur_y), 32'd0);
        check("async_reset busy", 32'(busy), 32'd0);
        check("async_reset char_ready", 32'(char_ready), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        observe("clear_after_reset", 2400, 8'h20, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
